// File: rtl/cpu_sram_resp_if.sv
// CPU-side SRAM bus bundle: instruction port and data port of the SRAM responder.
// The master drives requests; the slave returns registered read data.
// Request semantics: a port's en=1 at a rising edge is a complete request.
// No ready/ack exists; every enabled request finishes on that edge and its
// rdata is valid one cycle later, holding until the next enabled request.
interface cpu_sram_resp_if;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
        output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        input  inst_sram_rdata, data_sram_rdata
    );

    modport slave (
        input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
        input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        output inst_sram_rdata, data_sram_rdata
    );
endinterface

// File: rtl/cpu_sram_resp.sv
// Dual-port SRAM responder for a CPU: read-only instruction port plus a
// byte-writable data port with a small MMIO page (scratch register at 0x000,
// optional free-running timer at 0x004 when SRAM_RESP_TIMER_EN is defined).
// One-cycle read latency, read-first, never stalls. Illegal accesses set a
// sticky error flag that only reset clears. Backing store is not reset.
module cpu_sram_resp #(
    parameter int          MEM_AW    = 12,
    parameter logic [19:0] MMIO_PAGE = 20'hBFAFF
) (
    input  logic             clk,
    input  logic             reset,
    cpu_sram_resp_if.slave   bus,
    output logic             err_sticky
);
    localparam int DEPTH = 1 << MEM_AW;

    logic [31:0] mem [DEPTH];
    logic [31:0] scratch;
    logic [31:0] timer_rd;

    logic [MEM_AW-1:0] inst_idx;
    logic [MEM_AW-1:0] data_idx;
    logic              inst_in_range;
    logic              data_in_range;
    logic              data_mmio;
    logic              data_oob;
    logic [9:0]        mmio_word;
    logic              is_scratch;
    logic              is_timer;
    logic [31:0]       data_mask;
    logic [31:0]       mmio_rd;
    logic              unused_bits;

    assign inst_idx      = bus.inst_sram_addr[MEM_AW+1:2];
    assign data_idx      = bus.data_sram_addr[MEM_AW+1:2];
    assign inst_in_range = (bus.inst_sram_addr[31:MEM_AW+2] == '0);
    assign data_in_range = (bus.data_sram_addr[31:MEM_AW+2] == '0);
    // In-range decode takes priority so a misconfigured page can never shadow memory.
    assign data_mmio     = !data_in_range && (bus.data_sram_addr[31:12] == MMIO_PAGE);
    assign data_oob      = !data_in_range && !data_mmio;
    assign mmio_word     = bus.data_sram_addr[11:2];
    assign is_scratch    = data_mmio && (mmio_word == 10'd0);
    assign is_timer      = data_mmio && (mmio_word == 10'd1);

    // Byte-lane write mask derived from the data-port byte enables.
    assign data_mask = {{8{bus.data_sram_we[3]}}, {8{bus.data_sram_we[2]}},
                        {8{bus.data_sram_we[1]}}, {8{bus.data_sram_we[0]}}};

    // MMIO read mux; unmapped offsets read as zero.
    assign mmio_rd = is_scratch ? scratch :
                     is_timer   ? timer_rd : 32'h0;

    // Instruction write data and byte offsets carry no meaning here.
    assign unused_bits = ^{bus.inst_sram_wdata, bus.inst_sram_addr[1:0],
                           bus.data_sram_addr[1:0]};

`ifdef SRAM_RESP_TIMER_EN
    logic [31:0] timer;

    // Free-running timer; a full-word write loads it and beats the increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= 32'h0;
        end else if (bus.data_sram_en && is_timer && bus.data_sram_we == 4'hF) begin
            timer <= bus.data_sram_wdata;
        end else begin
            timer <= timer + 32'd1;
        end
    end

    assign timer_rd = timer;
`else
    assign timer_rd = 32'h0;
`endif

    // Backing store writes; gated by reset so a request held across the
    // reset-release edge is dropped, and never cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && bus.data_sram_en && data_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.data_sram_we[i]) begin
                    mem[data_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read data, scratch register and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.inst_sram_rdata <= 32'h0;
            bus.data_sram_rdata <= 32'h0;
            err_sticky          <= 1'b0;
            scratch             <= 32'h0;
        end else begin
            if (bus.inst_sram_en) begin
                bus.inst_sram_rdata <= inst_in_range ? mem[inst_idx] : 32'h0;
                if (!inst_in_range || bus.inst_sram_we != 4'h0) begin
                    err_sticky <= 1'b1;
                end
            end
            if (bus.data_sram_en) begin
                if (data_in_range) begin
                    bus.data_sram_rdata <= mem[data_idx];
                end else if (data_mmio) begin
                    bus.data_sram_rdata <= mmio_rd;
                end else begin
                    bus.data_sram_rdata <= 32'h0;
                end
                if (data_oob) begin
                    err_sticky <= 1'b1;
                end
                if (is_scratch) begin
                    scratch <= (scratch & ~data_mask) | (bus.data_sram_wdata & data_mask);
                end
            end
        end
    end
endmodule

// File: tb/tb_cpu_sram_resp.sv
// Bench for cpu_sram_resp: directed scenarios plus a randomized mix, each
// checked against a word-array model of memory, scratch and error state.
module tb_cpu_sram_resp;
    localparam logic [31:0] MEM_BYTES = 32'h4000;      // 2^12 words * 4
    localparam logic [31:0] MMIO_BASE = 32'hBFAFF000;

    logic clk = 1'b0;
    logic reset;
    logic err_sticky;

    cpu_sram_resp_if bus();

    cpu_sram_resp #(.MEM_AW(12), .MMIO_PAGE(20'hBFAFF)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_mem [0:4095];
    logic [31:0] m_scratch;
    logic [31:0] m_i_hold;
    logic [31:0] m_d_hold;
    logic        m_err;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic bit is_mmio(input logic [31:0] a);
        return a >= MEM_BYTES && (a & 32'hFFFFF000) == MMIO_BASE;
    endfunction

    function automatic logic [31:0] model_read_data(input logic [31:0] a);
        if (a < MEM_BYTES) return m_mem[int'(a >> 2)];
        if (is_mmio(a) && (a & 32'hFFC) == 32'h0) return m_scratch;
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_scratch = 0; m_i_hold = 0; m_d_hold = 0; m_err = 0;
    endtask

    // Drive one cycle of requests, advance the model, land #1 after the edge.
    task automatic access(input logic ien, input logic [3:0] iwe, input logic [31:0] iaddr,
                          input logic den, input logic [3:0] dwe, input logic [31:0] daddr,
                          input logic [31:0] dwd);
        bus.inst_sram_en = ien; bus.inst_sram_we = iwe; bus.inst_sram_addr = iaddr;
        bus.inst_sram_wdata = $urandom;
        bus.data_sram_en = den; bus.data_sram_we = dwe; bus.data_sram_addr = daddr;
        bus.data_sram_wdata = dwd;
        if (ien) begin
            if (iaddr < MEM_BYTES) m_i_hold = m_mem[int'(iaddr >> 2)];
            else begin m_i_hold = 0; m_err = 1; end
            if (iwe != 0) m_err = 1;
        end
        if (den) begin
            m_d_hold = model_read_data(daddr);
            if (daddr < MEM_BYTES) m_mem[int'(daddr >> 2)] = merge(m_mem[int'(daddr >> 2)], dwd, dwe);
            else if (is_mmio(daddr)) begin
                if ((daddr & 32'hFFC) == 0) m_scratch = merge(m_scratch, dwd, dwe);
            end else m_err = 1;
        end
        @(posedge clk); #1;
        bus.inst_sram_en = 0; bus.data_sram_en = 0;
        bus.inst_sram_we = 0; bus.data_sram_we = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        bus.inst_sram_en = 0; bus.inst_sram_we = 0; bus.inst_sram_addr = 0; bus.inst_sram_wdata = 0;
        bus.data_sram_en = 0; bus.data_sram_we = 0; bus.data_sram_addr = 0; bus.data_sram_wdata = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.inst_sram_rdata !== 32'h0) begin errors++; $display("FAIL reset_inst_rdata got %h want 0", bus.inst_sram_rdata); end
        checks++; if (bus.data_sram_rdata !== 32'h0) begin errors++; $display("FAIL reset_data_rdata got %h want 0", bus.data_sram_rdata); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_sticky); end
        reset = 0;
        // Preload the words the random mix uses so every read has a known value.
        for (int w = 0; w < 16; w++) access(0, 0, 0, 1, 4'hF, 32'(w * 4), $urandom);
        access(0, 0, 0, 1, 4'hF, 32'h44, 32'h0BAD_F00D);
    endtask

    task automatic test_write_read();
        access(0, 0, 0, 1, 4'hF, 32'h40, 32'h12345678);
        access(1, 0, 32'h40, 0, 0, 0, 0);
        checks++; if (bus.inst_sram_rdata !== 32'h12345678) begin errors++; $display("FAIL write_read got %h want 12345678", bus.inst_sram_rdata); end
        @(posedge clk); #1;
        checks++; if (bus.inst_sram_rdata !== 32'h12345678) begin errors++; $display("FAIL rdata_hold got %h want 12345678", bus.inst_sram_rdata); end
    endtask

    task automatic test_byte_enable();
        access(0, 0, 0, 1, 4'b0010, 32'h41, 32'hAABBCCDD);
        access(0, 0, 0, 1, 4'h0, 32'h42, 32'h0);
        checks++; if (bus.data_sram_rdata !== 32'h1234CC78) begin errors++; $display("FAIL byte_enable got %h want 1234cc78", bus.data_sram_rdata); end
    endtask

    task automatic test_same_edge();
        access(1, 0, 32'h40, 1, 4'hF, 32'h40, 32'hFFFFFFFF);
        checks++; if (bus.inst_sram_rdata !== 32'h1234CC78) begin errors++; $display("FAIL same_edge_old got %h want 1234cc78", bus.inst_sram_rdata); end
        checks++; if (bus.data_sram_rdata !== 32'h1234CC78) begin errors++; $display("FAIL same_edge_data_old got %h want 1234cc78", bus.data_sram_rdata); end
        access(1, 0, 32'h40, 0, 0, 0, 0);
        checks++; if (bus.inst_sram_rdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL same_edge_new got %h want ffffffff", bus.inst_sram_rdata); end
    endtask

    task automatic test_mmio();
        access(0, 0, 0, 1, 4'hF, MMIO_BASE, 32'hCAFEF00D);
        access(0, 0, 0, 1, 4'b1000, MMIO_BASE, 32'h11223344);
        checks++; if (bus.data_sram_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL scratch_full got %h want cafef00d", bus.data_sram_rdata); end
        access(0, 0, 0, 1, 4'hF, MMIO_BASE + 32'h800, 32'h55555555);
        checks++; if (bus.data_sram_rdata !== 32'h0) begin errors++; $display("FAIL mmio_unmapped got %h want 0", bus.data_sram_rdata); end
        access(0, 0, 0, 1, 4'h0, MMIO_BASE, 32'h0);
        checks++; if (bus.data_sram_rdata !== 32'h11FEF00D) begin errors++; $display("FAIL scratch_byte got %h want 11fef00d", bus.data_sram_rdata); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL mmio_no_err got %b want 0", err_sticky); end
    endtask

    task automatic test_timer();
`ifdef SRAM_RESP_TIMER_EN
        access(0, 0, 0, 1, 4'hF, MMIO_BASE + 32'h4, 32'hFFFFFFFE);
        access(0, 0, 0, 1, 4'h0, MMIO_BASE + 32'h4, 32'h0);
        checks++; if (bus.data_sram_rdata !== 32'hFFFFFFFE) begin errors++; $display("FAIL timer_load got %h want fffffffe", bus.data_sram_rdata); end
        access(0, 0, 0, 1, 4'h0, MMIO_BASE + 32'h4, 32'h0);
        checks++; if (bus.data_sram_rdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL timer_inc got %h want ffffffff", bus.data_sram_rdata); end
        access(0, 0, 0, 1, 4'h0, MMIO_BASE + 32'h4, 32'h0);
        checks++; if (bus.data_sram_rdata !== 32'h0) begin errors++; $display("FAIL timer_wrap got %h want 0", bus.data_sram_rdata); end
        access(0, 0, 0, 1, 4'h3, MMIO_BASE + 32'h4, 32'h0);
        access(0, 0, 0, 1, 4'h0, MMIO_BASE + 32'h4, 32'h0);
        checks++; if (bus.data_sram_rdata !== 32'h2) begin errors++; $display("FAIL timer_partial got %h want 2", bus.data_sram_rdata); end
`else
        access(0, 0, 0, 1, 4'hF, MMIO_BASE + 32'h4, 32'h12345678);
        access(0, 0, 0, 1, 4'h0, MMIO_BASE + 32'h4, 32'h0);
        checks++; if (bus.data_sram_rdata !== 32'h0) begin errors++; $display("FAIL timer_absent got %h want 0", bus.data_sram_rdata); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] ia, da;
        for (int n = 0; n < 300; n++) begin
            ia = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0, 1:    da = MMIO_BASE + 32'($urandom_range(0, 3));
                2:       da = MMIO_BASE + 32'($urandom_range(2, 1023) * 4);
                default: da = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            endcase
            access(1'($urandom_range(0, 1)), 0, ia, 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 15)), da, $urandom);
            checks++; if (bus.inst_sram_rdata !== m_i_hold) begin errors++; $display("FAIL rand_inst[%0d] got %h want %h", n, bus.inst_sram_rdata, m_i_hold); end
            checks++; if (bus.data_sram_rdata !== m_d_hold) begin errors++; $display("FAIL rand_data[%0d] got %h want %h", n, bus.data_sram_rdata, m_d_hold); end
            checks++; if (err_sticky !== m_err) begin errors++; $display("FAIL rand_err[%0d] got %b want %b", n, err_sticky, m_err); end
        end
    endtask

    task automatic test_out_of_range();
        access(0, 0, 0, 1, 4'hF, 32'h00100000, 32'hDEADBEEF);
        checks++; if (bus.data_sram_rdata !== 32'h0) begin errors++; $display("FAIL oob_rdata got %h want 0", bus.data_sram_rdata); end
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL oob_err got %b want 1", err_sticky); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL oob_err_held got %b want 1", err_sticky); end
        access(1, 0, 32'h0, 0, 0, 0, 0);
        checks++; if (bus.inst_sram_rdata !== m_i_hold) begin errors++; $display("FAIL oob_no_write got %h want %h", bus.inst_sram_rdata, m_i_hold); end
    endtask

    task automatic pulse_reset();
        #2 reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic test_inst_write();
        pulse_reset();
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL err_cleared got %b want 0", err_sticky); end
        access(1, 4'h1, 32'h44, 0, 0, 0, 0);
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL inst_we_err got %b want 1", err_sticky); end
        access(0, 0, 0, 1, 4'h0, 32'h44, 32'h0);
        checks++; if (bus.data_sram_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL inst_we_ignored got %h want 0badf00d", bus.data_sram_rdata); end
    endtask

    task automatic test_reset_midstream();
        access(0, 0, 0, 1, 4'hF, 32'h40, 32'h12345678);
        access(0, 0, 0, 1, 4'h0, 32'h40, 32'h0);
        checks++; if (bus.data_sram_rdata !== 32'h12345678) begin errors++; $display("FAIL pre_reset got %h want 12345678", bus.data_sram_rdata); end
        #2 reset = 1;
        model_reset();
        #1;
        checks++; if (bus.data_sram_rdata !== 32'h0) begin errors++; $display("FAIL async_reset_rdata got %h want 0", bus.data_sram_rdata); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL async_reset_err got %b want 0", err_sticky); end
        @(posedge clk); #1;
        // A write held through the last reset edge must be dropped.
        bus.data_sram_en = 1; bus.data_sram_we = 4'hF; bus.data_sram_addr = 32'h40;
        bus.data_sram_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        reset = 0;
        bus.data_sram_en = 0; bus.data_sram_we = 0;
        access(1, 0, 32'h40, 1, 4'h0, 32'h40, 32'h0);
        checks++; if (bus.inst_sram_rdata !== 32'h12345678) begin errors++; $display("FAIL post_reset_inst got %h want 12345678", bus.inst_sram_rdata); end
        checks++; if (bus.data_sram_rdata !== 32'h12345678) begin errors++; $display("FAIL post_reset_data got %h want 12345678", bus.data_sram_rdata); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_same_edge();
        test_mmio();
        test_timer();
        test_random();
        test_out_of_range();
        test_inst_write();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
